uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Serial UART transmitter; the transmit-side counterpart to the team's oversampling UART receiver.
- Accepts one parallel word per handshake and shifts it out LSB-first on TX_OUT, framed as start bit, DATA_WIDTH data bits, optional parity bit, and one stop bit.
- Each bit is held for Prescale clock cycles, so Prescale, PAR_EN and PAR_TYP match the receiver's configuration and the two ends interoperate on the same clock.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
Data_Valid  input  1  request; P_DATA/config accepted when high and busy low
PAR_EN  input  1  1 = parity bit inserted after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  6  clock cycles per bit; 0 treated as 1
TX_OUT  output  1  serial line, idle high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (RST low, asynchronous, any state, including mid-frame):
  - state = IDLE, TX_OUT = 1, busy = 0.
  - Shift register, parity, bit counter and cycle counter = 0.
  - Frame in progress is abandoned; no partial resume after release.
- All outputs are registered. No combinational path from inputs to TX_OUT or busy.
- Acceptance:
  - On the rising edge where Data_Valid = 1 and busy = 0 (IDLE), latch P_DATA, PAR_EN, PAR_TYP and Prescale (0 mapped to 1) into internal registers.
  - At that same edge: TX_OUT <= 0, busy <= 1, state <= START, cycle counter <= 0.
- Data_Valid while busy = 1 is ignored; the word is not queued.
- Input changes after acceptance (P_DATA, PAR_EN, PAR_TYP, Prescale) have no effect on the current frame.
- Parity is computed once at acceptance: par = ^P_DATA for even, ~(^P_DATA) for odd.
- Cycle counter:
  - Counts 0..Pl-1 in every bit state, where Pl is the latched Prescale.
  - Reaching Pl-1 is the bit end; the next state and next TX_OUT value load on that edge and the counter returns to 0.
  - Every bit is exactly Pl cycles wide.
- State machine (TX_OUT value held during each state):
  - IDLE (TX_OUT 1): go to START on acceptance.
  - START (TX_OUT 0): at bit end go to DATA, bit counter <= 0, TX_OUT <= data[0].
  - DATA (TX_OUT data[bit counter]):
    - At bit end, if bit counter < DATA_WIDTH-1: increment bit counter, TX_OUT <= next bit.
    - Else: go to PARITY (TX_OUT <= par) if latched PAR_EN = 1, otherwise go to STOP (TX_OUT <= 1).
  - PARITY (TX_OUT par): at bit end go to STOP, TX_OUT <= 1.
  - STOP (TX_OUT 1): at bit end go to IDLE, busy <= 0.
- Frame length in cycles:
  - Pl*(DATA_WIDTH+2) without parity; Pl*(DATA_WIDTH+3) with parity.
  - busy is high for exactly that many cycles.
- Back-to-back frames:
  - Data_Valid held high is accepted on the first edge after busy falls.
  - The line is therefore high for Pl+1 cycles between frames (stop bit plus one idle cycle).
- Pl = 1: every state lasts exactly one cycle; the frame is DATA_WIDTH+2 (or +3) cycles.
- Bit counter width: clog2(DATA_WIDTH). No wrap past DATA_WIDTH-1.

Test Plan:
- Reset, then idle with Data_Valid = 0 for 50 cycles -> TX_OUT = 1 and busy = 0 throughout.
- Prescale = 8, PAR_EN = 1, PAR_TYP = 0, P_DATA = 0xA5, one-cycle Data_Valid -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0,1, each 8 cycles wide; busy high for exactly 88 cycles.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 1, P_DATA = 0x00 -> parity bit = 1; frame 176 cycles. Repeat with PAR_EN = 0, P_DATA = 0xFF -> bits 0, eight 1s, stop 1; 160 cycles.
- Data_Valid held high with P_DATA changing every cycle, Prescale = 4 -> only the words sampled at the edges where busy = 0 are sent; gap of 5 high cycles between frames. Mid-frame changes to Prescale and PAR_EN do not alter the current frame.
- Pulse RST low in DATA state at bit 3 -> TX_OUT = 1 and busy = 0 immediately (asynchronous). After release, a new Data_Valid starts a clean frame from the start bit.
- Prescale = 0 and Prescale = 1, P_DATA = 0x3C, no parity -> both produce a 10-cycle frame 0,0,0,1,1,1,1,0,0,1.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Every bit is held for the Prescale value latched when the word is accepted.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_par_en;
  logic                  w_par_en_nxt;
  logic [5:0]            r_pl;
  logic [5:0]            w_pl_nxt;
  logic [5:0]            r_cnt;
  logic [5:0]            w_cnt_nxt;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_bit_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_end;

  assign w_end  = (r_cnt == r_pl - 6'd1);
  assign TX_OUT = r_tx;
  assign busy   = r_busy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_pl     <= 6'd1;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_par_en <= w_par_en_nxt;
      r_pl     <= w_pl_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_par_en_nxt = r_par_en;
    w_pl_nxt     = r_pl;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_end ? 6'd0 : r_cnt + 6'd1;
    end
    unique case (r_state)
      S_IDLE: begin
        if (Data_Valid) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = P_DATA;
          w_par_nxt    = (^P_DATA) ^ PAR_TYP;
          w_par_en_nxt = PAR_EN;
          w_pl_nxt     = (Prescale == 6'd0) ? 6'd1 : Prescale;
          w_cnt_nxt    = '0;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end
      S_START: begin
        if (w_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_end) begin
          if (r_bit < LAST_BIT) begin
            // shift right so the next bit is always at index 1
            w_bit_nxt   = r_bit + BW'(1);
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end else if (r_par_en) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_end) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: checks every serial bit cycle by cycle
// against a frame built from the word and config the bench sends.
module tb_uart_tx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = '0;
  logic       TX_OUT;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic pe,
                        input logic pt, input logic [5:0] ps);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
  endtask

  // Checks one frame starting at the first negedge after acceptance,
  // then the idle cycle that follows the stop bit.
  task automatic frame(input string tag, input logic [7:0] d,
                       input logic pe, input logic pt, input int pl,
                       input bit scram);
    logic exp_b[12];
    int   n;
    int   hi;
    n = 0;
    exp_b[n++] = 1'b0;
    for (int i = 0; i < 8; i++) exp_b[n++] = d[i];
    if (pe) exp_b[n++] = (^d) ^ pt;
    exp_b[n++] = 1'b1;
    hi = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < pl; c++) begin
        @(negedge CLK);
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(TX_OUT),
            32'(exp_b[b]));
        if (busy === 1'b1) hi++;
        if (scram) begin
          P_DATA   = 8'($urandom);
          Prescale = 6'($urandom);
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
      end
    end
    chk({tag, "_busy_len"}, 32'(hi), 32'(n * pl));
    @(negedge CLK);
    chk({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    RST = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      chk($sformatf("idle_tx_%0d", i), 32'(TX_OUT), 32'd1);
      chk($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
    end

    launch(8'hA5, 1'b1, 1'b0, 6'd8);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 8, 1'b0);

    launch(8'h00, 1'b1, 1'b1, 6'd16);
    frame("00_odd", 8'h00, 1'b1, 1'b1, 16, 1'b0);

    launch(8'hFF, 1'b0, 1'b0, 6'd16);
    frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 16, 1'b0);

    // held Data_Valid with inputs scrambled during each frame
    @(negedge CLK);
    P_DATA     = 8'h11;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    frame("b2b0", 8'h11, 1'b0, 1'b0, 4, 1'b1);
    P_DATA   = 8'h3C;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd4;
    frame("b2b1", 8'h3C, 1'b0, 1'b0, 4, 1'b1);
    P_DATA   = 8'hE7;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    Prescale = 6'd4;
    frame("b2b2", 8'hE7, 1'b1, 1'b1, 4, 1'b1);
    Data_Valid = 1'b0;
    @(negedge CLK);
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_tx", 32'(TX_OUT), 32'd1);

    // asynchronous reset in the middle of data bit 3
    launch(8'hA5, 1'b0, 1'b0, 6'd4);
    repeat (18) @(negedge CLK);
    chk("pre_rst_tx", 32'(TX_OUT), 32'd0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    chk("async_rst_tx", 32'(TX_OUT), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_tx", 32'(TX_OUT), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    launch(8'h96, 1'b1, 1'b0, 6'd2);
    frame("post_rst", 8'h96, 1'b1, 1'b0, 2, 1'b0);

    launch(8'h3C, 1'b0, 1'b0, 6'd0);
    frame("ps0", 8'h3C, 1'b0, 1'b0, 1, 1'b0);
    launch(8'h3C, 1'b0, 1'b0, 6'd1);
    frame("ps1", 8'h3C, 1'b0, 1'b0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
